// File: rtl/counter_sequence_monitor_if.sv
// Bundle of the monitored count bus and the monitor's health-summary outputs.
// The master side drives the sample; the slave side is the monitor itself.
interface counter_sequence_monitor_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
);
    logic             sample_vld;
    logic [WIDTH-1:0] cnt_in;
    logic             locked;
    logic             err_pulse;
    logic [ERR_W-1:0] err_cnt;
    logic             wrap_pulse;
    logic [ERR_W-1:0] wrap_cnt;
    logic [WIDTH-1:0] exp_cnt;

    modport master (
        output sample_vld, cnt_in,
        input  locked, err_pulse, err_cnt, wrap_pulse, wrap_cnt, exp_cnt
    );

    modport slave (
        input  sample_vld, cnt_in,
        output locked, err_pulse, err_cnt, wrap_pulse, wrap_cnt, exp_cnt
    );
endinterface

// File: rtl/counter_sequence_monitor.sv
// Receiving-end checker for an increment-by-one counter bus. Acquires lock
// after LOCK_CNT consecutive in-sequence samples, then reports every break
// (error) and every legal all-ones -> zero wrap. All outputs are registered.
module counter_sequence_monitor #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 3,
    parameter int ERR_W    = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    counter_sequence_monitor_if.slave     bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACQ    = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Match counter only needs to reach LOCK_CNT, which is at most 15.
    localparam logic [4:0] LOCK_TGT = 5'(LOCK_CNT);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] exp_q, exp_d;
    logic [3:0]       mcnt_q, mcnt_d;
    logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
    logic [ERR_W-1:0] wrap_cnt_q, wrap_cnt_d;
    logic             err_pulse_q, err_pulse_d;
    logic             wrap_pulse_q, wrap_pulse_d;
    logic             locked_q;

    logic [WIDTH-1:0] cnt_plus1;
    logic             match;
    logic [4:0]       mcnt_inc;

    assign cnt_plus1 = bus.cnt_in + WIDTH'(1);
    assign match     = (bus.cnt_in == exp_q);
    assign mcnt_inc  = {1'b0, mcnt_q} + 5'd1;

    // State register and all registered outputs; reset clears everything at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            exp_q        <= '0;
            mcnt_q       <= '0;
            err_cnt_q    <= '0;
            wrap_cnt_q   <= '0;
            err_pulse_q  <= 1'b0;
            wrap_pulse_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            state_q      <= state_d;
            exp_q        <= exp_d;
            mcnt_q       <= mcnt_d;
            err_cnt_q    <= err_cnt_d;
            wrap_cnt_q   <= wrap_cnt_d;
            err_pulse_q  <= err_pulse_d;
            wrap_pulse_q <= wrap_pulse_d;
            locked_q     <= (state_d == LOCKED);
        end
    end

    // Next-state and event decode; invalid cycles hold everything and drop pulses.
    always_comb begin
        state_d      = state_q;
        exp_d        = exp_q;
        mcnt_d       = mcnt_q;
        err_cnt_d    = err_cnt_q;
        wrap_cnt_d   = wrap_cnt_q;
        err_pulse_d  = 1'b0;
        wrap_pulse_d = 1'b0;

        if (bus.sample_vld) begin
            // Every valid sample re-seeds the expectation, match or not.
            exp_d = cnt_plus1;
            case (state_q)
                IDLE: begin
                    mcnt_d  = '0;
                    state_d = ACQ;
                end
                ACQ: begin
                    if (match) begin
                        mcnt_d = mcnt_inc[3:0];
                        if (mcnt_inc == LOCK_TGT) begin
                            state_d = LOCKED;
                        end
                    end else begin
                        mcnt_d = '0;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        if (bus.cnt_in == '0) begin
                            wrap_pulse_d = 1'b1;
                            if (!(&wrap_cnt_q)) begin
                                wrap_cnt_d = wrap_cnt_q + ERR_W'(1);
                            end
                        end
                    end else begin
                        // Break: the offending value seeds reacquisition.
                        err_pulse_d = 1'b1;
                        if (!(&err_cnt_q)) begin
                            err_cnt_d = err_cnt_q + ERR_W'(1);
                        end
                        mcnt_d  = '0;
                        state_d = ACQ;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign bus.locked     = locked_q;
    assign bus.err_pulse  = err_pulse_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.wrap_pulse = wrap_pulse_q;
    assign bus.wrap_cnt   = wrap_cnt_q;
    assign bus.exp_cnt    = exp_q;
endmodule

// File: tb/tb_counter_sequence_monitor.sv
// Bench for counter_sequence_monitor: two instances (8-bit and 2-bit error
// counters) share one stimulus stream and are checked each cycle against a
// run-length model, plus directed scenarios with literal expectations.
module tb_counter_sequence_monitor;
    localparam int LOCK_CNT = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       vld = 1'b0;
    logic [3:0] cnt_val = '0;
    bit         chk_en = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    counter_sequence_monitor_if #(.WIDTH(4), .ERR_W(8)) bus0 ();
    counter_sequence_monitor_if #(.WIDTH(4), .ERR_W(2)) bus1 ();

    assign bus0.sample_vld = vld;
    assign bus0.cnt_in     = cnt_val;
    assign bus1.sample_vld = vld;
    assign bus1.cnt_in     = cnt_val;

    counter_sequence_monitor #(.WIDTH(4), .LOCK_CNT(LOCK_CNT), .ERR_W(8)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    counter_sequence_monitor #(.WIDTH(4), .LOCK_CNT(LOCK_CNT), .ERR_W(2)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    // Model: "seeded" flag, length of the current run of in-sequence samples,
    // and a locked flag; counters saturate at m_max.
    int m_seeded[2], m_run[2], m_locked[2], m_exp[2];
    int m_err[2], m_wrap[2], m_ep[2], m_wp[2];
    int m_max[2] = '{255, 3};

    task automatic chk(input string name, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
        end
    endtask

    task model_reset();
        for (int d = 0; d < 2; d++) begin
            m_seeded[d] = 0; m_run[d] = 0; m_locked[d] = 0; m_exp[d] = 0;
            m_err[d] = 0; m_wrap[d] = 0; m_ep[d] = 0; m_wp[d] = 0;
        end
    endtask

    task model_update(input bit v, input int c);
        for (int d = 0; d < 2; d++) begin
            m_ep[d] = 0;
            m_wp[d] = 0;
            if (v) begin
                if (m_seeded[d] == 0) begin
                    m_seeded[d] = 1;
                    m_run[d] = 0;
                end else if (m_locked[d] != 0) begin
                    if (c == m_exp[d]) begin
                        if (c == 0) begin
                            m_wp[d] = 1;
                            if (m_wrap[d] < m_max[d]) m_wrap[d]++;
                        end
                    end else begin
                        m_ep[d] = 1;
                        if (m_err[d] < m_max[d]) m_err[d]++;
                        m_locked[d] = 0;
                        m_run[d] = 0;
                    end
                end else begin
                    m_run[d] = (c == m_exp[d]) ? m_run[d] + 1 : 0;
                    if (m_run[d] >= LOCK_CNT) m_locked[d] = 1;
                end
                m_exp[d] = (c + 1) % 16;
            end
        end
    endtask

    // One clock of stimulus; returns at the following falling edge.
    task step(input bit v, input int c);
        vld = v;
        cnt_val = 4'(c);
        @(posedge clk);
        model_update(v, c);
        @(negedge clk);
    endtask

    task feed(input int c);
        step(1'b1, c);
        $display("[TB] sample %0d -> locked=%0d err_p=%0d err_cnt=%0d wrap_p=%0d wrap_cnt=%0d exp=%0d",
                 c, bus0.locked, bus0.err_pulse, bus0.err_cnt, bus0.wrap_pulse, bus0.wrap_cnt, bus0.exp_cnt);
    endtask

    task chk_all_zero(input string tag);
        chk({tag, "_locked"},  int'(bus0.locked), 0);
        chk({tag, "_errp"},    int'(bus0.err_pulse), 0);
        chk({tag, "_errcnt"},  int'(bus0.err_cnt), 0);
        chk({tag, "_wrapp"},   int'(bus0.wrap_pulse), 0);
        chk({tag, "_wrapcnt"}, int'(bus0.wrap_cnt), 0);
        chk({tag, "_exp"},     int'(bus0.exp_cnt), 0);
        chk({tag, "_errcnt1"}, int'(bus1.err_cnt), 0);
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (!rst && chk_en) begin
            chk("m_locked0",  int'(bus0.locked),     m_locked[0]);
            chk("m_errp0",    int'(bus0.err_pulse),  m_ep[0]);
            chk("m_errcnt0",  int'(bus0.err_cnt),    m_err[0]);
            chk("m_wrapp0",   int'(bus0.wrap_pulse), m_wp[0]);
            chk("m_wrapcnt0", int'(bus0.wrap_cnt),   m_wrap[0]);
            chk("m_exp0",     int'(bus0.exp_cnt),    m_exp[0]);
            chk("m_locked1",  int'(bus1.locked),     m_locked[1]);
            chk("m_errp1",    int'(bus1.err_pulse),  m_ep[1]);
            chk("m_errcnt1",  int'(bus1.err_cnt),    m_err[1]);
            chk("m_wrapcnt1", int'(bus1.wrap_cnt),   m_wrap[1]);
        end
    end

    int base;
    int pulses1;

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        chk_en = 1'b1;

        // No error before lock: 7 breaks the run but only re-seeds.
        feed(2); feed(3); feed(7); feed(8); feed(9);
        chk("prelock_locked", int'(bus0.locked), 0);
        feed(10);
        chk("lock_after_10", int'(bus0.locked), 1);
        chk("prelock_errcnt", int'(bus0.err_cnt), 0);

        // Wrap while locked.
        for (int v = 11; v <= 15; v++) feed(v);
        feed(0);
        chk("wrap_pulse", int'(bus0.wrap_pulse), 1);
        chk("wrap_cnt", int'(bus0.wrap_cnt), 1);
        chk("wrap_no_err", int'(bus0.err_pulse), 0);
        feed(1);
        chk("wrap_pulse_drop", int'(bus0.wrap_pulse), 0);

        // Break: locked on ...,3,4 then 9.
        feed(2); feed(3); feed(4);
        feed(9);
        chk("brk_errp", int'(bus0.err_pulse), 1);
        chk("brk_errcnt", int'(bus0.err_cnt), 1);
        chk("brk_locked", int'(bus0.locked), 0);
        chk("brk_exp", int'(bus0.exp_cnt), 10);
        feed(10); feed(11);
        chk("brk_errp_drop", int'(bus0.err_pulse), 0);
        chk("relock_pending", int'(bus0.locked), 0);
        feed(12);
        chk("relock_12", int'(bus0.locked), 1);

        // Valid gaps: walk to exp_cnt = 6, then idle 5 cycles.
        for (int v = 13; v <= 20; v++) feed(v % 16);
        feed(5);
        chk("gap_exp_before", int'(bus0.exp_cnt), 6);
        for (int i = 0; i < 5; i++) step(1'b0, 9);
        chk("gap_locked", int'(bus0.locked), 1);
        chk("gap_exp_hold", int'(bus0.exp_cnt), 6);
        feed(6);
        chk("gap_exp_after", int'(bus0.exp_cnt), 7);
        chk("gap_errp", int'(bus0.err_pulse), 0);
        chk("gap_locked2", int'(bus0.locked), 1);

        // Saturation of the 2-bit instance: 4 more breaks (5 total).
        pulses1 = 1;
        base = 7;
        for (int b = 2; b <= 5; b++) begin
            base = (base + 5) % 16;
            feed(base);
            if (bus1.err_pulse) pulses1++;
            if (b == 3) chk("sat_errcnt_3rd", int'(bus1.err_cnt), 3);
            for (int k = 1; k <= 3; k++) feed((base + k) % 16);
            base = (base + 4) % 16;
            chk("sat_relock", int'(bus1.locked), 1);
        end
        chk("sat_errcnt_hold", int'(bus1.err_cnt), 3);
        chk("sat_pulses", pulses1, 5);
        chk("wide_errcnt", int'(bus0.err_cnt), 5);

        // Asynchronous reset mid-cycle while locked.
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk_all_zero("async_rst");
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        feed(5); feed(6); feed(7);
        chk("rst_relock_pending", int'(bus0.locked), 0);
        feed(8);
        chk("rst_relock_8", int'(bus0.locked), 1);

        // Randomized run, mostly in-sequence with occasional breaks and gaps.
        for (int i = 0; i < 1500; i++) begin
            bit v;
            int c;
            v = ($urandom_range(0, 3) != 0);
            c = ($urandom_range(0, 9) < 8) ? m_exp[0] : int'($urandom_range(0, 15));
            step(v, c);
        end

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/counter_sequence_monitor.md
# counter_sequence_monitor

Receiving-end checker for the free-running 4-bit up-counter: it samples the counter's output bus, acquires lock on the increment-by-one sequence, and then flags every sequence break and every wrap-around. It sits beside the counter in the same clock domain. It gives benches and on-chip debug a registered health summary: lock status, error pulse and count, wrap pulse and count.

## Interface
- `WIDTH`, default 4: width of the monitored count bus.
- `LOCK_CNT`, default 3: consecutive in-sequence samples needed to declare lock (valid range 1..15).
- `ERR_W`, default 8: width of the saturating error and wrap counters.

- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  asynchronous, active-high reset; one clock domain only.
- `sample_vld`  in  1  high when `cnt_in` holds a sample to check this cycle.
- `cnt_in`  in  WIDTH  counter value under observation.
- `locked`  out  1  high while in LOCKED.
- `err_pulse`  out  1  one-cycle pulse on each sequence break detected while LOCKED.
- `err_cnt`  out  ERR_W  number of sequence breaks; saturates at all-ones.
- `wrap_pulse`  out  1  one-cycle pulse when a locked sample wraps from all-ones to zero.
- `wrap_cnt`  out  ERR_W  number of wraps; saturates at all-ones.
- `exp_cnt`  out  WIDTH  value the next valid sample must equal.

## Operation
- States: IDLE, ACQ, LOCKED.
- Reset (async, asserted) forces the following, regardless of clock:
  - state IDLE;
  - `locked`, `err_pulse`, `wrap_pulse` = 0;
  - `err_cnt`, `wrap_cnt`, `exp_cnt` = 0;
  - internal match counter `mcnt` = 0.
- A cycle with `sample_vld` = 0 is ignored entirely. State, `exp_cnt` and `mcnt` hold, and both pulses are 0.
- Increment arithmetic: `exp_cnt` ← `cnt_in` + 1, modulo 2^WIDTH. All-ones + 1 = 0. The wrap is legal, not an error.
- IDLE, valid sample:
  - `exp_cnt` ← `cnt_in` + 1; `mcnt` ← 0; go to ACQ.
  - No error is reported.
- ACQ, valid sample, `cnt_in` == `exp_cnt`:
  - `mcnt` ← `mcnt` + 1.
  - If `mcnt` + 1 == LOCK_CNT, go to LOCKED.
  - `exp_cnt` ← `cnt_in` + 1.
- ACQ, valid sample, mismatch:
  - `mcnt` ← 0; `exp_cnt` ← `cnt_in` + 1; stay in ACQ.
  - No error is reported (not yet locked).
- LOCKED, valid sample, match:
  - `exp_cnt` ← `cnt_in` + 1.
  - If `cnt_in` == 0, assert `wrap_pulse` and increment `wrap_cnt` (saturating).
- LOCKED, valid sample, mismatch:
  - Assert `err_pulse`; increment `err_cnt` (saturating).
  - `mcnt` ← 0; `exp_cnt` ← `cnt_in` + 1; go to ACQ, so the new value seeds reacquisition.
  - No wrap is reported on a mismatching sample, even if `cnt_in` == 0.
- Saturation: at all-ones, `err_cnt` and `wrap_cnt` hold. The pulses still fire.
- `locked` is a registered decode of state == LOCKED.

## Timing
- Every output is registered. The response to the sample taken at rising edge N is visible immediately after edge N and stable for cycle N+1. Latency is 1 cycle.
- `err_pulse` and `wrap_pulse` stay high for exactly one cycle per triggering sample. They deassert at the next edge even if `sample_vld` = 0.
- Lock timing with continuous valid in-sequence samples from IDLE: `locked` rises after sample LOCK_CNT+1 (the first sample only seeds). With LOCK_CNT = 3, that is the 4th sample edge.
- `locked` falls at the same edge that raises `err_pulse`.
- Reset asserted mid-operation clears everything asynchronously. After deassertion, the first valid sample re-seeds from IDLE. No pulse may occur on the reset-release edge.
- Gaps in `sample_vld` do not break lock and do not advance `exp_cnt`.

## Test plan
- **Reset values:** assert `rst` mid-cycle after lock is reached.
  - Every output goes to 0 with no clock edge.
  - After release, samples 5,6,7,8 give `locked` = 1 after the edge for 8.
- **Wrap:** locked, then feed 14,15,0,1.
  - One `wrap_pulse` at the 0 sample; `wrap_cnt` 0→1; `err_pulse` stays 0.
- **Break:** locked on …,3,4, then feed 9.
  - `err_pulse` = 1 for one cycle; `err_cnt` = 1; `locked` = 0; `exp_cnt` = 10.
  - Then 10,11,12 relock after the 12 edge.
- **Valid gaps:** locked with `exp_cnt` = 6; hold `sample_vld` = 0 for 5 cycles, then feed 6.
  - No pulses; `locked` stays 1; `exp_cnt` = 7.
- **No error before lock:** from reset, feed 2,3,7,8,9,10.
  - `err_cnt` stays 0.
  - `locked` rises after the 10 edge (mismatch at 7 re-seeds; 8,9,10 give 3 matches).
- **Saturation:** with ERR_W = 2, force 5 breaks while relocking between them.
  - `err_cnt` = 3 after the 3rd break and holds.
  - `err_pulse` fires all 5 times.
